fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline. Owns the PC and drives the byte address into the

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the IF/ID register payload.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          WORD_BYTES   = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Purpose: pipeline register for if_id_t with bubble insertion.
// Latency: 1 cycle from d to q.
// Backpressure: stall holds q; flush overrides stall and loads a bubble.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t bubble;

  always_comb begin
    bubble          = '0;
    bubble.valid    = 1'b0;
    bubble.instr    = BUBBLE_INSTR;
    bubble.pc_plus4 = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= bubble;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: IF stage; owns the PC, addresses the combinational ROM, fills IF/ID.
// Latency: 1 cycle PC to IF/ID; a redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; a redirect still moves the PC during stall.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR  = mips_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           pc,
  output logic                  if_id_valid,
  output logic [31:0]           if_id_instr,
  output logic [31:0]           if_id_pc_plus4,
  output logic                  fetch_fault,
  output logic [31:0]           fetch_count
);

  logic [31:0] pc_plus4;
  logic        capture;
  logic        pc_beyond_rom;
  logic        redirect_misaligned;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign pc_plus4            = pc + WORD_BYTES;
  assign imem_addr           = pc[ADDR_WIDTH-1:0];
  // Any PC bit above the ROM window means the ROM is aliasing.
  assign pc_beyond_rom       = (pc >> ADDR_WIDTH) != 32'h0;
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign capture             = !flush && !redirect_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      if (redirect_misaligned || (capture && pc_beyond_rom)) begin
        fetch_fault <= 1'b1;
      end
      if (capture) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  always_comb begin
    if_id_d          = '0;
    if_id_d.valid    = 1'b1;
    if_id_d.instr    = imem_rdata;
    if_id_d.pc_plus4 = pc_plus4;
  end

  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush || redirect_valid),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_valid    = if_id_q.valid;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;

endmodule
